// File: rtl/ring_pattern_gen.sv
// Ring/beep waveform generator: continuous tone, repeating bursts with gaps, or a single beep.
// Latency: 1 cycle from the en rising edge to the first clk_ring/busy update.
// Backpressure: none; free-running once started, en low aborts the run on the next edge.
module ring_pattern_gen #(
    parameter int CNT_W      = 27,
    parameter int PERIOD_DEF = 25_000_000,
    parameter int BURST_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [CNT_W-1:0]   period,
    input  logic [CNT_W-1:0]   high_time,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [BURST_W-1:0] gap_periods,
    output logic               clk_ring,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_CONT   = 2'b01;
    localparam logic [1:0] MODE_BURST  = 2'b10;
    localparam logic [1:0] MODE_SINGLE = 2'b11;

    localparam logic [CNT_W-1:0]   PL_RST    = CNT_W'(PERIOD_DEF);
    localparam logic [CNT_W-1:0]   HL_RST    = CNT_W'(PERIOD_DEF / 2);
    localparam logic [CNT_W-1:0]   P_MIN     = CNT_W'(2);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   m_q, m_d;
    logic [CNT_W-1:0]   pl_q, pl_d;
    logic [CNT_W-1:0]   hl_q, hl_d;
    logic [BURST_W-1:0] pcnt_q, pcnt_d;
    logic [BURST_W-1:0] bl_q, bl_d;
    logic [BURST_W-1:0] gl_q, gl_d;
    logic [1:0]         model_q, model_d;
    logic               en_prev_q, en_prev_d;
    logic               armed_q, armed_d;
    logic               ring_q, ring_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Start qualification, clamped config and period/phase counter helpers.
    // armed_q blocks a start until en has been seen low since reset, so a level
    // held high across reset release never counts as a rising edge.
    logic               start;
    logic               wrap;
    logic               burst_end;
    logic               gap_end;
    logic [CNT_W-1:0]   m_inc;
    logic [BURST_W-1:0] pcnt_inc;
    logic [CNT_W-1:0]   p_clamp;
    logic [CNT_W-1:0]   h_clamp;
    logic [BURST_W-1:0] b_clamp;

    assign start     = (state_q == ST_IDLE) && en && !en_prev_q && armed_q && (mode != MODE_OFF);
    assign p_clamp   = (period < P_MIN) ? P_MIN : period;
    assign h_clamp   = (high_time > p_clamp) ? p_clamp : high_time;
    assign b_clamp   = (burst_len == '0) ? BURST_ONE : burst_len;
    assign wrap      = (m_q == (pl_q - CNT_ONE));
    assign m_inc     = wrap ? '0 : (m_q + CNT_ONE);
    assign pcnt_inc  = pcnt_q + BURST_ONE;
    assign burst_end = (pcnt_inc == bl_q);
    assign gap_end   = (pcnt_inc == gl_q);

    // State and datapath registers; reset clears outputs immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            pcnt_q    <= '0;
            pl_q      <= PL_RST;
            hl_q      <= HL_RST;
            bl_q      <= BURST_ONE;
            gl_q      <= '0;
            model_q   <= MODE_OFF;
            en_prev_q <= 1'b0;
            armed_q   <= 1'b0;
            ring_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            pcnt_q    <= pcnt_d;
            pl_q      <= pl_d;
            hl_q      <= hl_d;
            bl_q      <= bl_d;
            gl_q      <= gl_d;
            model_q   <= model_d;
            en_prev_q <= en_prev_d;
            armed_q   <= armed_d;
            ring_q    <= ring_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state: abort on en low wins over any wrap-driven transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_TONE;
                end
            end
            ST_TONE: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (wrap) begin
                    if (model_q == MODE_SINGLE) begin
                        state_d = ST_IDLE;
                    end else if ((model_q == MODE_BURST) && burst_end && (gl_q != '0)) begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (wrap && gap_end) begin
                    state_d = ST_TONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs and counters: clk_ring is precomputed from the next counter value so
    // the registered waveform is high for exactly Hl of every Pl cycles.
    always_comb begin
        m_d       = m_q;
        pcnt_d    = pcnt_q;
        pl_d      = pl_q;
        hl_d      = hl_q;
        bl_d      = bl_q;
        gl_d      = gl_q;
        model_d   = model_q;
        ring_d    = 1'b0;
        done_d    = 1'b0;
        busy_d    = (state_d != ST_IDLE);
        en_prev_d = en;
        armed_d   = armed_q | ~en;
        case (state_q)
            ST_IDLE: begin
                m_d    = '0;
                pcnt_d = '0;
                if (start) begin
                    pl_d    = p_clamp;
                    hl_d    = h_clamp;
                    bl_d    = b_clamp;
                    gl_d    = gap_periods;
                    model_d = mode;
                    ring_d  = (h_clamp != '0);
                end
            end
            ST_TONE: begin
                if (!en) begin
                    m_d    = '0;
                    pcnt_d = '0;
                end else begin
                    m_d    = m_inc;
                    ring_d = (m_inc < hl_q);
                    if (wrap) begin
                        case (model_q)
                            MODE_SINGLE: begin
                                ring_d = 1'b0;
                                done_d = 1'b1;
                            end
                            MODE_BURST: begin
                                if (burst_end) begin
                                    pcnt_d = '0;
                                    if (gl_q != '0) begin
                                        ring_d = 1'b0;
                                    end else begin
                                        done_d = 1'b1;
                                    end
                                end else begin
                                    pcnt_d = pcnt_inc;
                                end
                            end
                            MODE_CONT: ;
                            default: ;
                        endcase
                    end
                end
            end
            ST_GAP: begin
                if (!en) begin
                    m_d    = '0;
                    pcnt_d = '0;
                end else begin
                    m_d = m_inc;
                    if (wrap) begin
                        if (gap_end) begin
                            pcnt_d = '0;
                            done_d = 1'b1;
                            ring_d = (hl_q != '0);
                        end else begin
                            pcnt_d = pcnt_inc;
                        end
                    end
                end
            end
            default: begin
                m_d    = '0;
                pcnt_d = '0;
            end
        endcase
    end

    assign clk_ring = ring_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ring_pattern_gen.sv
// Testbench for ring_pattern_gen: directed vector table, hand sequences, random vs. reference model.
module tb_ring_pattern_gen;

    localparam int CW = 27;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [CW-1:0] period = '0;
    logic [CW-1:0] high_time = '0;
    logic [BW-1:0] burst_len = '0;
    logic [BW-1:0] gap_periods = '0;
    logic          clk_ring;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    ring_pattern_gen dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .mode        (mode),
        .period      (period),
        .high_time   (high_time),
        .burst_len   (burst_len),
        .gap_periods (gap_periods),
        .clk_ring    (clk_ring),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Reference model: waveform as a function of cycles since start.
    bit         mr_run = 1'b0;
    int         mt = 0;
    int         mp = 2;
    int         mh = 0;
    int         mb = 1;
    int         mg = 0;
    logic [1:0] mmode = 2'b00;
    bit         men_prev = 1'b0;
    bit         marmed = 1'b0;
    bit         exp_ring = 1'b0;
    bit         exp_busy = 1'b0;
    bit         exp_done = 1'b0;

    task automatic model_reset();
        mr_run   = 1'b0;
        men_prev = 1'b0;
        marmed   = 1'b0;
        exp_ring = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
    endtask

    task automatic model_edge();
        int len;
        int u;
        exp_done = 1'b0;
        if (mr_run) begin
            if (!en) begin
                mr_run = 1'b0;
            end else begin
                mt++;
                len = (mb + mg) * mp;
                if (mmode == 2'b11 && mt == mp) begin
                    mr_run   = 1'b0;
                    exp_done = 1'b1;
                end else if (mmode == 2'b10 && (mt % len) == 0) begin
                    exp_done = 1'b1;
                end
            end
        end else if (en && !men_prev && marmed && mode != 2'b00) begin
            mr_run = 1'b1;
            mt     = 0;
            mp     = (int'(period) < 2) ? 2 : int'(period);
            mh     = (int'(high_time) > mp) ? mp : int'(high_time);
            mb     = (burst_len == 0) ? 1 : int'(burst_len);
            mg     = int'(gap_periods);
            mmode  = mode;
        end
        men_prev = en;
        if (!en) marmed = 1'b1;
        exp_busy = mr_run;
        exp_ring = 1'b0;
        if (mr_run) begin
            len = (mb + mg) * mp;
            u   = mt % len;
            case (mmode)
                2'b01:   exp_ring = ((mt % mp) < mh);
                2'b10:   exp_ring = (u < mb * mp) && ((u % mp) < mh);
                default: exp_ring = (mt < mh);
            endcase
        end
    endtask

    // One clock: model follows the inputs seen at the edge, sampling happens 1 ns later.
    task automatic tick();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic chk(input string name, input logic [2:0] exp);
        logic [2:0] act;
        act = {clk_ring, busy, done};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: ring/busy/done got %b expected %b", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  md;
        int          p;
        int          h;
        int          b;
        int          g;
        logic [23:0] ring;
        logic [23:0] bsy;
        logic [23:0] dn;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // Bit 23 is the cycle right after the start edge.
        vecs[0] = '{2'b01, 4, 2, 0, 0, 24'b1100_1100_1100_1100_1100_1100, 24'hFFFFFF, 24'h000000};
        vecs[1] = '{2'b11, 5, 3, 0, 0, 24'b1110_0000_0000_0000_0000_0000,
                    24'b1111_1000_0000_0000_0000_0000, 24'b0000_0100_0000_0000_0000_0000};
        vecs[2] = vecs[1];
        vecs[3] = '{2'b10, 4, 1, 2, 1, 24'b1000_1000_0000_1000_1000_0000, 24'hFFFFFF,
                    24'b0000_0000_0000_1000_0000_0000};
        vecs[4] = '{2'b10, 4, 1, 2, 0, 24'b1000_1000_1000_1000_1000_1000, 24'hFFFFFF,
                    24'b0000_0000_1000_0000_1000_0000};
        vecs[5] = '{2'b01, 1, 1, 0, 0, 24'hAAAAAA, 24'hFFFFFF, 24'h000000};
        vecs[6] = '{2'b01, 4, 9, 0, 0, 24'hFFFFFF, 24'hFFFFFF, 24'h000000};
        vecs[7] = '{2'b01, 4, 0, 0, 0, 24'h000000, 24'hFFFFFF, 24'h000000};
        vecs[8] = '{2'b10, 4, 1, 0, 1, 24'b1000_0000_1000_0000_1000_0000, 24'hFFFFFF,
                    24'b0000_0000_1000_0000_1000_0000};
        vecs[9] = '{2'b00, 4, 2, 0, 0, 24'h000000, 24'h000000, 24'h000000};

        model_reset();
        #1;
        chk("reset_state", 3'b000);
        #11;
        reset = 1'b0;

        // Directed table.
        for (int k = 0; k < 10; k++) begin
            mode        = vecs[k].md;
            period      = CW'(vecs[k].p);
            high_time   = CW'(vecs[k].h);
            burst_len   = BW'(vecs[k].b);
            gap_periods = BW'(vecs[k].g);
            en = 1'b0;
            tick();
            en = 1'b1;
            for (int i = 0; i < 24; i++) begin
                tick();
                chk($sformatf("vec%0d_cyc%0d", k, i),
                    {vecs[k].ring[23-i], vecs[k].bsy[23-i], vecs[k].dn[23-i]});
            end
            en = 1'b0;
            tick();
            chk($sformatf("vec%0d_abort", k), 3'b000);
        end

        // Config change mid-run has no effect until the next start.
        mode      = 2'b01;
        period    = CW'(4);
        high_time = CW'(2);
        en        = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("cfg_hold_cyc%0d", i), {((i % 4) < 2) ? 1'b1 : 1'b0, 1'b1, 1'b0});
            if (i == 2) begin
                period    = CW'(8);
                high_time = CW'(6);
            end
        end
        en = 1'b0;
        tick();
        chk("cfg_hold_abort", 3'b000);

        // Reset during burst TONE at m=1, then en held high across release.
        mode        = 2'b10;
        period      = CW'(4);
        high_time   = CW'(1);
        burst_len   = BW'(2);
        gap_periods = BW'(1);
        en          = 1'b1;
        tick();
        chk("rst_seq_start", 3'b110);
        tick();
        chk("rst_seq_m1", 3'b010);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_async", 3'b000);
        tick();
        chk("rst_held", 3'b000);
        #3;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rst_no_start%0d", i), 3'b000);
        end
        en = 1'b0;
        tick();
        chk("rst_en_low", 3'b000);
        en = 1'b1;
        tick();
        chk("rst_restart", 3'b110);

        // Random stimulus against the reference model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 29) == 0) en = ~en;
            if ($urandom_range(0, 3) == 0) begin
                mode        = 2'($urandom_range(0, 3));
                period      = CW'($urandom_range(1, 9));
                high_time   = CW'($urandom_range(0, 10));
                burst_len   = BW'($urandom_range(0, 3));
                gap_periods = BW'($urandom_range(0, 3));
            end
            tick();
            chk($sformatf("rand%0d", c), {exp_ring, exp_busy, exp_done});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
